mc_control_fsm: RTL and testbench
=================================

Name: mc_control_fsm

Overview:
- Multicycle sequencer for the MIPS datapath. It replaces the single-cycle main decoder with a Moore FSM that steps each instruction through fetch, decode, execute, memory and writeback.
- A shared ALU and a unified instruction/data memory are reused across cycles.
- Supported opcodes are the existing set: RTYPE, LW, SW, BEQ, ADDI, J, LUI, LB. Memory accesses wait on a ready handshake.
- A retired-instruction counter is included for bring-up.

Parameters:
- CNT_W, 32, width of retired_count.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- op  input  6  opcode from the instruction register (IR).
- funct  input  6  funct field from IR.
- Zero  input  1  ALU zero flag.
- mem_ready  input  1  memory completes the current read/write this cycle.
- c_MemRead  output  1  memory read request.
- c_MemWrite  output  1  memory write request.
- c_IorD  output  1  address select: 0 = PC, 1 = ALUOut.
- c_IRWrite  output  1  load IR.
- c_PCWrite  output  1  PC enable; already includes the branch condition.
- c_PCSrc  output  2  PC source: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- c_RegWrite  output  1  register file write.
- c_RegDst  output  1  destination: 1 = rd, 0 = rt.
- c_MemToReg  output  1  writeback source: 1 = memory data, 0 = ALUOut.
- c_ALUSrcA  output  2  00 = PC, 01 = A register, 10 = constant 16.
- c_ALUSrcB  output  2  00 = B register, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2.
- c_ALUControl  output  3  same encoding as the existing ALU decoder.
- c_MemoryByte  output  1  byte-load path (LB).
- c_Illegal  output  1  one-cycle pulse on an unsupported op or funct.
- retired_count  output  CNT_W  count of completed instructions.

Behaviour:
- Outputs are a function of the state register only (Moore). Exceptions: c_PCWrite depends on Zero in BEQEX and on mem_ready in FETCH; c_IRWrite depends on mem_ready in FETCH.
- Any output not listed for a state is 0.
- Reset: reset_n low immediately forces state IDLE, all outputs 0 and retired_count 0. This holds when reset is asserted mid-instruction, including during a memory wait.
- IDLE: all outputs 0. Next state is FETCH unconditionally.
- FETCH: MemRead=1, IorD=0, SrcA=00, SrcB=01, ALUOp=00, PCSrc=00, IRWrite=PCWrite=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: SrcA=00, SrcB=11, ALUOp=00 (precomputes the branch target into ALUOut). Next state by op:
  - LW, LB, SW -> MEMADR.
  - RTYPE with a legal funct -> RTYPEEX.
  - BEQ -> BEQEX; ADDI -> ADDIEX; LUI -> LUIEX; J -> JEX.
  - Anything else -> TRAP.
  - Legal functs: 100000, 100010, 100100, 100101, 101010, 000100.
- MEMADR: SrcA=01, SrcB=10, ALUOp=00. Next: SW -> MEMWR, otherwise MEMRD.
- MEMRD: MemRead=1, IorD=1, MemoryByte=(op==LB). Waits for mem_ready, then MEMWB.
- MEMWB: RegWrite=1, RegDst=0, MemToReg=1, MemoryByte=(op==LB). Next: FETCH.
- MEMWR: MemWrite=1, IorD=1. MemWrite is held until mem_ready, then FETCH.
- RTYPEEX: SrcA=01, SrcB=00, ALUOp=10. Next: RTYPEWB.
- RTYPEWB: RegWrite=1, RegDst=1. Next: FETCH.
- BEQEX: SrcA=01, SrcB=00, ALUOp=01, PCSrc=01, PCWrite=Zero. Next: FETCH.
- ADDIEX: SrcA=01, SrcB=10, ALUOp=00. Next: IMMWB.
- LUIEX: SrcA=10, SrcB=10, ALUOp=11 (sllv: SignImm<<16). Next: IMMWB.
- IMMWB: RegWrite=1, RegDst=0, MemToReg=0. Next: FETCH.
- JEX: PCSrc=10, PCWrite=1. Next: FETCH.
- TRAP: c_Illegal=1 for one cycle; no register or memory writes; PC is already advanced by FETCH. Next: FETCH.
- ALUOp-to-c_ALUControl mapping:
  - 00 -> 010 (add); 01 -> 110 (subtract); 11 -> 100 (shift).
  - 10 -> decoded from funct as in the existing ALU decoder.
  - c_ALUControl is never X, because illegal functs never reach RTYPEEX.
- Latency with zero-wait memory (mem_ready=1 in FETCH, MEMRD and MEMWR):
  - BEQ and J: 3 cycles.
  - RTYPE, ADDI, LUI and SW: 4 cycles.
  - LW and LB: 5 cycles.
  - Each cycle of mem_ready=0 adds one cycle.
- retired_count:
  - Increments by 1 on every transition into FETCH from MEMWB, MEMWR, RTYPEWB, BEQEX, IMMWB or JEX.
  - Does not increment from IDLE or TRAP.
  - Wraps modulo 2^CNT_W.
- mem_ready outside FETCH, MEMRD and MEMWR is ignored.

Decomposition:
- Package mc_pkg holds:
  - the state enum mc_state_t (IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, LUIEX, IMMWB, JEX, TRAP);
  - opcode and funct localparams;
  - the ALUSrcA, ALUSrcB and PCSrc encodings.
- One sub-module: instantiate the existing ALUDecoder unchanged for the ALUOp/funct -> c_ALUControl mapping.

Test Plan:
- Reset: assert reset_n=0 during MEMRD with mem_ready=0 -> all outputs 0 and retired_count=0 the same cycle; after release, one IDLE cycle, then FETCH with MemRead=1.
- RTYPE add (op=000000, funct=100000), mem_ready=1 -> states FETCH, DECODE, RTYPEEX, RTYPEWB; ALUControl=010 in RTYPEEX; RegWrite=RegDst=1 in the 4th cycle; count +1.
- LB (op=100000) with mem_ready low for 2 cycles in MEMRD -> MemRead=IorD=MemoryByte=1 for 3 cycles, then MEMWB with MemToReg=1 and MemoryByte=1; total 7 cycles.
- BEQ (op=000100): Zero=1 -> PCWrite=1 and PCSrc=01 in BEQEX. Zero=0 -> PCWrite=0. Both cases take 3 cycles.
- LUI (op=001111) -> LUIEX with SrcA=10, SrcB=10, ALUControl=100, then IMMWB with RegWrite=1 and RegDst=0.
- Illegal op=111111 and RTYPE funct=000000 -> TRAP with c_Illegal=1 for exactly 1 cycle; RegWrite and MemWrite never asserted; retired_count unchanged.

Source files
------------

// File: rtl/mc_control_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_pkg
// Description : Shared types, opcode/funct constants, datapath select
//               encodings and the Moore output table for mc_control_fsm.
// Revision    : 1.0 - initial release
// ============================================================================
package mc_pkg;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        FETCH   = 4'd1,
        DECODE  = 4'd2,
        MEMADR  = 4'd3,
        MEMRD   = 4'd4,
        MEMWB   = 4'd5,
        MEMWR   = 4'd6,
        RTYPEEX = 4'd7,
        RTYPEWB = 4'd8,
        BEQEX   = 4'd9,
        ADDIEX  = 4'd10,
        LUIEX   = 4'd11,
        IMMWB   = 4'd12,
        JEX     = 4'd13,
        TRAP    = 4'd14
    } mc_state_t;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_LUI   = 6'b001111;
    localparam logic [5:0] c_OP_LB    = 6'b100000;

    localparam logic [5:0] c_FN_ADD  = 6'b100000;
    localparam logic [5:0] c_FN_SUB  = 6'b100010;
    localparam logic [5:0] c_FN_AND  = 6'b100100;
    localparam logic [5:0] c_FN_OR   = 6'b100101;
    localparam logic [5:0] c_FN_SLT  = 6'b101010;
    localparam logic [5:0] c_FN_SLLV = 6'b000100;

    localparam logic [1:0] c_SRCA_PC    = 2'b00;
    localparam logic [1:0] c_SRCA_A     = 2'b01;
    localparam logic [1:0] c_SRCA_C16   = 2'b10;

    localparam logic [1:0] c_SRCB_B     = 2'b00;
    localparam logic [1:0] c_SRCB_FOUR  = 2'b01;
    localparam logic [1:0] c_SRCB_IMM   = 2'b10;
    localparam logic [1:0] c_SRCB_IMMSH = 2'b11;

    localparam logic [1:0] c_PCSRC_ALU    = 2'b00;
    localparam logic [1:0] c_PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] c_PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] c_ALUOP_ADD   = 2'b00;
    localparam logic [1:0] c_ALUOP_SUB   = 2'b01;
    localparam logic [1:0] c_ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] c_ALUOP_SHIFT = 2'b11;

    // alu_en gates c_ALUControl to zero in states that do not use the ALU.
    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       alu_en;
        logic       mem_byte;
        logic       illegal;
    } mc_ctl_t;

    function automatic logic funct_legal(input logic [5:0] funct);
        return (funct == c_FN_ADD) || (funct == c_FN_SUB) || (funct == c_FN_AND) ||
               (funct == c_FN_OR)  || (funct == c_FN_SLT) || (funct == c_FN_SLLV);
    endfunction

    function automatic mc_ctl_t state_ctl(input mc_state_t s, input logic is_lb);
        mc_ctl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_a = c_SRCA_PC;
                c.alu_src_b = c_SRCB_FOUR;
                c.alu_op    = c_ALUOP_ADD;
                c.alu_en    = 1'b1;
                c.pc_src    = c_PCSRC_ALU;
            end
            DECODE: begin
                c.alu_src_a = c_SRCA_PC;
                c.alu_src_b = c_SRCB_IMMSH;
                c.alu_op    = c_ALUOP_ADD;
                c.alu_en    = 1'b1;
            end
            MEMADR, ADDIEX: begin
                c.alu_src_a = c_SRCA_A;
                c.alu_src_b = c_SRCB_IMM;
                c.alu_op    = c_ALUOP_ADD;
                c.alu_en    = 1'b1;
            end
            MEMRD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
                c.mem_byte = is_lb;
            end
            MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.mem_byte   = is_lb;
            end
            MEMWR: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            RTYPEEX: begin
                c.alu_src_a = c_SRCA_A;
                c.alu_src_b = c_SRCB_B;
                c.alu_op    = c_ALUOP_FUNCT;
                c.alu_en    = 1'b1;
            end
            RTYPEWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            BEQEX: begin
                c.alu_src_a = c_SRCA_A;
                c.alu_src_b = c_SRCB_B;
                c.alu_op    = c_ALUOP_SUB;
                c.alu_en    = 1'b1;
                c.pc_src    = c_PCSRC_ALUOUT;
            end
            LUIEX: begin
                c.alu_src_a = c_SRCA_C16;
                c.alu_src_b = c_SRCB_IMM;
                c.alu_op    = c_ALUOP_SHIFT;
                c.alu_en    = 1'b1;
            end
            IMMWB:   c.reg_write = 1'b1;
            JEX: begin
                c.pc_src   = c_PCSRC_JUMP;
                c.pc_write = 1'b1;
            end
            TRAP:    c.illegal = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_control_fsm_aludec.sv
`default_nettype none
// ============================================================================
// Module      : ALUDecoder
// Description : Maps ALUOp and the R-type funct field to the ALU control code.
// Revision    : 1.0 - initial release
// ============================================================================
module ALUDecoder
    import mc_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = 3'b010;
        case (aluop)
            c_ALUOP_ADD:   alucontrol = 3'b010;
            c_ALUOP_SUB:   alucontrol = 3'b110;
            c_ALUOP_SHIFT: alucontrol = 3'b100;
            default: begin
                case (funct)
                    c_FN_ADD:  alucontrol = 3'b010;
                    c_FN_SUB:  alucontrol = 3'b110;
                    c_FN_AND:  alucontrol = 3'b000;
                    c_FN_OR:   alucontrol = 3'b001;
                    c_FN_SLT:  alucontrol = 3'b111;
                    c_FN_SLLV: alucontrol = 3'b100;
                    default:   alucontrol = 3'b010;
                endcase
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : mc_control_fsm
// Description : Moore control sequencer for the multicycle MIPS datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_control_fsm
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             c_MemRead,
    output logic             c_MemWrite,
    output logic             c_IorD,
    output logic             c_IRWrite,
    output logic             c_PCWrite,
    output logic [1:0]       c_PCSrc,
    output logic             c_RegWrite,
    output logic             c_RegDst,
    output logic             c_MemToReg,
    output logic [1:0]       c_ALUSrcA,
    output logic [1:0]       c_ALUSrcB,
    output logic [2:0]       c_ALUControl,
    output logic             c_MemoryByte,
    output logic             c_Illegal,
    output logic [CNT_W-1:0] retired_count
);

    mc_state_t        r_state;
    mc_state_t        w_next;
    mc_ctl_t          r_ctl;
    logic [CNT_W-1:0] r_count;
    logic             w_retire;
    logic [2:0]       w_alu_dec;

    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:    w_next = FETCH;
            FETCH:   w_next = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    c_OP_LW, c_OP_LB, c_OP_SW: w_next = MEMADR;
                    c_OP_RTYPE: w_next = funct_legal(funct) ? RTYPEEX : TRAP;
                    c_OP_BEQ:   w_next = BEQEX;
                    c_OP_ADDI:  w_next = ADDIEX;
                    c_OP_LUI:   w_next = LUIEX;
                    c_OP_J:     w_next = JEX;
                    default:    w_next = TRAP;
                endcase
            end
            MEMADR:  w_next = (op == c_OP_SW) ? MEMWR : MEMRD;
            MEMRD:   w_next = mem_ready ? MEMWB : MEMRD;
            MEMWR:   w_next = mem_ready ? FETCH : MEMWR;
            RTYPEEX: w_next = RTYPEWB;
            ADDIEX:  w_next = IMMWB;
            LUIEX:   w_next = IMMWB;
            MEMWB, RTYPEWB, BEQEX, IMMWB, JEX, TRAP: w_next = FETCH;
            default: w_next = IDLE;
        endcase
    end

    // Only completed instructions retire; IDLE and TRAP entries into FETCH do not.
    assign w_retire = (w_next == FETCH) &&
                      ((r_state == MEMWB) || (r_state == MEMWR) || (r_state == RTYPEWB) ||
                       (r_state == BEQEX) || (r_state == IMMWB) || (r_state == JEX));

    // Outputs are registered from the next-state decode, so they track r_state exactly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_ctl   <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            r_ctl   <= state_ctl(w_next, op == c_OP_LB);
            if (w_retire) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    ALUDecoder u_aludec (
        .aluop      (r_ctl.alu_op),
        .funct      (funct),
        .alucontrol (w_alu_dec)
    );

    assign c_MemRead     = r_ctl.mem_read;
    assign c_MemWrite    = r_ctl.mem_write;
    assign c_IorD        = r_ctl.iord;
    assign c_IRWrite     = (r_state == FETCH) && mem_ready;
    assign c_PCWrite     = r_ctl.pc_write ||
                           ((r_state == FETCH) && mem_ready) ||
                           ((r_state == BEQEX) && Zero);
    assign c_PCSrc       = r_ctl.pc_src;
    assign c_RegWrite    = r_ctl.reg_write;
    assign c_RegDst      = r_ctl.reg_dst;
    assign c_MemToReg    = r_ctl.mem_to_reg;
    assign c_ALUSrcA     = r_ctl.alu_src_a;
    assign c_ALUSrcB     = r_ctl.alu_src_b;
    assign c_ALUControl  = r_ctl.alu_en ? w_alu_dec : 3'b000;
    assign c_MemoryByte  = r_ctl.mem_byte;
    assign c_Illegal     = r_ctl.illegal;
    assign retired_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_control_fsm
// Description : Self-checking bench: per-instruction expected cycle plans.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_control_fsm;

    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [5:0]       op, funct;
    logic             Zero, mem_ready;
    logic             c_MemRead, c_MemWrite, c_IorD, c_IRWrite, c_PCWrite;
    logic [1:0]       c_PCSrc;
    logic             c_RegWrite, c_RegDst, c_MemToReg;
    logic [1:0]       c_ALUSrcA, c_ALUSrcB;
    logic [2:0]       c_ALUControl;
    logic             c_MemoryByte, c_Illegal;
    logic [CNT_W-1:0] retired_count;

    always #5 clk = ~clk;

    mc_control_fsm #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .Zero(Zero),
        .mem_ready(mem_ready), .c_MemRead(c_MemRead), .c_MemWrite(c_MemWrite),
        .c_IorD(c_IorD), .c_IRWrite(c_IRWrite), .c_PCWrite(c_PCWrite),
        .c_PCSrc(c_PCSrc), .c_RegWrite(c_RegWrite), .c_RegDst(c_RegDst),
        .c_MemToReg(c_MemToReg), .c_ALUSrcA(c_ALUSrcA), .c_ALUSrcB(c_ALUSrcB),
        .c_ALUControl(c_ALUControl), .c_MemoryByte(c_MemoryByte),
        .c_Illegal(c_Illegal), .retired_count(retired_count)
    );

    typedef struct packed {
        logic       mr, mw, iord, irw, pcw;
        logic [1:0] pcsrc;
        logic       rw, rd, m2r;
        logic [1:0] sa, sb;
        logic [2:0] alu;
        logic       mb, ill;
    } ctl_t;

    typedef struct {
        ctl_t  c;
        bit    waits;
        bit    fetch;
        bit    beq;
        string tag;
    } step_t;

    step_t plan[$];
    int    compared     = 0;
    int    mismatched   = 0;
    int    exp_count    = 0;
    int    forced_waits = -1;
    int    zero_mode    = -1;

    function automatic ctl_t got_ctl();
        return {c_MemRead, c_MemWrite, c_IorD, c_IRWrite, c_PCWrite, c_PCSrc,
                c_RegWrite, c_RegDst, c_MemToReg, c_ALUSrcA, c_ALUSrcB,
                c_ALUControl, c_MemoryByte, c_Illegal};
    endfunction

    task automatic chk_ctl(input string tag, input ctl_t exp);
        ctl_t got;
        got = got_ctl();
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s op=%b funct=%b: observed %h expected %h", tag, op, funct, got, exp);
        end
    endtask

    task automatic chk_cnt(input string tag);
        compared++;
        assert (retired_count === CNT_W'(exp_count)) else begin
            mismatched++;
            $error("FAIL %s: observed count %0d expected %0d", tag, retired_count, exp_count);
        end
    endtask

    function automatic logic [2:0] rtype_alu(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b100;
        endcase
    endfunction

    function automatic bit funct_ok(input logic [5:0] f);
        return f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000100};
    endfunction

    function automatic void add(input ctl_t c, input bit w, input bit f, input bit b, input string t);
        step_t s;
        s.c = c; s.waits = w; s.fetch = f; s.beq = b; s.tag = t;
        plan.push_back(s);
    endfunction

    // Expands one instruction into its expected per-cycle control pattern; returns 1 if it retires.
    function automatic bit build_plan(input logic [5:0] o, input logic [5:0] f);
        ctl_t c;
        bit   retires = 1'b1;
        plan.delete();
        c = '0; c.mr = 1; c.sb = 2'b01; c.alu = 3'b010;  add(c, 1, 1, 0, "fetch");
        c = '0; c.sb = 2'b11; c.alu = 3'b010;            add(c, 0, 0, 0, "decode");
        if (o == 6'b100011 || o == 6'b100000 || o == 6'b101011) begin
            c = '0; c.sa = 2'b01; c.sb = 2'b10; c.alu = 3'b010; add(c, 0, 0, 0, "memadr");
            if (o == 6'b101011) begin
                c = '0; c.mw = 1; c.iord = 1;                   add(c, 1, 0, 0, "memwr");
            end else begin
                c = '0; c.mr = 1; c.iord = 1; c.mb = (o == 6'b100000); add(c, 1, 0, 0, "memrd");
                c = '0; c.rw = 1; c.m2r = 1; c.mb = (o == 6'b100000);  add(c, 0, 0, 0, "memwb");
            end
        end else if (o == 6'b000000 && funct_ok(f)) begin
            c = '0; c.sa = 2'b01; c.alu = rtype_alu(f);      add(c, 0, 0, 0, "rtypeex");
            c = '0; c.rw = 1; c.rd = 1;                      add(c, 0, 0, 0, "rtypewb");
        end else if (o == 6'b000100) begin
            c = '0; c.sa = 2'b01; c.alu = 3'b110; c.pcsrc = 2'b01; add(c, 0, 0, 1, "beqex");
        end else if (o == 6'b001000 || o == 6'b001111) begin
            c = '0; c.sb = 2'b10;
            c.sa  = (o == 6'b001111) ? 2'b10 : 2'b01;
            c.alu = (o == 6'b001111) ? 3'b100 : 3'b010;      add(c, 0, 0, 0, "immex");
            c = '0; c.rw = 1;                                add(c, 0, 0, 0, "immwb");
        end else if (o == 6'b000010) begin
            c = '0; c.pcsrc = 2'b10; c.pcw = 1;              add(c, 0, 0, 0, "jex");
        end else begin
            c = '0; c.ill = 1;                               add(c, 0, 0, 0, "trap");
            retires = 1'b0;
        end
        return retires;
    endfunction

    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int abort_at);
        bit   retires;
        ctl_t exp;
        int   waited;
        retires = build_plan(o, f);
        for (int i = 0; i < plan.size(); i++) begin
            waited = 0;
            do begin
                @(negedge clk);
                if (i == 0) begin
                    op = o; funct = f;
                end
                if (forced_waits >= 0)
                    mem_ready = plan[i].fetch ? 1'b1 : (waited >= forced_waits);
                else
                    mem_ready = ($urandom_range(0, 3) != 0);
                if (plan[i].waits && waited >= 6) mem_ready = 1'b1;
                if (i == abort_at) mem_ready = 1'b0;
                Zero = (zero_mode >= 0) ? zero_mode[0] : 1'($urandom_range(0, 1));
                #1;
                exp = plan[i].c;
                if (plan[i].fetch) begin
                    exp.irw = mem_ready; exp.pcw = mem_ready;
                end
                if (plan[i].beq) exp.pcw = Zero;
                chk_ctl(plan[i].tag, exp);
                if (i == 0) chk_cnt("count_at_fetch");
                if (i == abort_at) begin
                    reset_n = 1'b0;
                    #1;
                    exp_count = 0;
                    chk_ctl("reset_midwait", '0);
                    chk_cnt("reset_midwait_count");
                    @(negedge clk);
                    reset_n = 1'b1;
                    #1;
                    chk_ctl("idle_after_reset", '0);
                    return;
                end
                waited++;
            end while (plan[i].waits && !mem_ready);
        end
        if (retires) exp_count++;
    endtask

    task automatic run_random();
        logic [5:0] o, f;
        int k;
        k = $urandom_range(0, 9);
        f = 6'($urandom_range(0, 63));
        case (k)
            0: begin o = 6'b000000; f = (f[0]) ? 6'b100101 : 6'b101010; end
            1: o = 6'b000000;
            2: o = 6'b100011;
            3: o = 6'b101011;
            4: o = 6'b000100;
            5: o = 6'b001000;
            6: o = 6'b000010;
            7: o = 6'b001111;
            8: o = 6'b100000;
            default: begin
                o = 6'($urandom_range(0, 63));
                if (o inside {6'b000000, 6'b100011, 6'b101011, 6'b000100,
                              6'b001000, 6'b000010, 6'b001111, 6'b100000})
                    o = 6'b111111;
            end
        endcase
        run_instr(o, f, -1);
    endtask

    initial begin
        reset_n = 1'b0; op = 6'b000000; funct = 6'b100000; Zero = 1'b1; mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk_ctl("reset", '0);
        chk_cnt("reset_count");
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk_ctl("idle", '0);

        forced_waits = 0;
        run_instr(6'b000000, 6'b100000, -1);   // add
        forced_waits = 2;
        run_instr(6'b100000, 6'b000000, -1);   // lb with two wait cycles
        forced_waits = 0;
        zero_mode = 1;
        run_instr(6'b000100, 6'b000000, -1);   // beq taken
        zero_mode = 0;
        run_instr(6'b000100, 6'b000000, -1);   // beq not taken
        zero_mode = -1;
        run_instr(6'b001111, 6'b000000, -1);   // lui
        run_instr(6'b111111, 6'b100000, -1);   // illegal op
        run_instr(6'b000000, 6'b000000, -1);   // illegal funct
        run_instr(6'b101011, 6'b000000, -1);   // sw
        run_instr(6'b000010, 6'b000000, -1);   // j

        forced_waits = -1;
        for (int n = 0; n < 80; n++) run_random();

        forced_waits = 0;
        run_instr(6'b100011, 6'b000000, 3);    // reset while waiting in the load read
        run_instr(6'b001000, 6'b000000, -1);
        run_instr(6'b000000, 6'b100010, -1);
        @(negedge clk);
        #1;
        chk_cnt("final_count");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
